// File: rtl/div_seq_if.sv
// Request/response bundle between the execute stage and the divide sequencer.
// The execute stage drives the request side; the divider returns HI/LO and a stall.
interface div_seq_if #(
    parameter int DATA_W = 32
);
    logic                  start;
    logic                  annul;
    logic                  signed_div;
    logic [DATA_W-1:0]     opdata1;
    logic [DATA_W-1:0]     opdata2;
    logic [2*DATA_W-1:0]   result;
    logic                  ready;
    logic                  stall_req;

    modport master (
        output start, annul, signed_div, opdata1, opdata2,
        input  result, ready, stall_req
    );

    modport slave (
        input  start, annul, signed_div, opdata1, opdata2,
        output result, ready, stall_req
    );
endinterface

// File: rtl/div_seq.sv
// Multi-cycle radix-2 restoring divider for MIPS32 DIV/DIVU.
// Works on operand magnitudes and fixes the signs when loading {HI, LO}.
module div_seq #(
    parameter int DATA_W = 32
) (
    input  logic     clk,
    input  logic     rst,
    div_seq_if.slave bus
);
    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {IDLE, BYZERO, RUN, DONE} state_t;

    state_t                state, state_next;
    logic [CNT_W-1:0]      cnt, cnt_next;
    logic [2*DATA_W:0]     work, work_next;
    logic [DATA_W-1:0]     divisor, divisor_next;
    logic                  sign_q, sign_q_next;
    logic                  sign_r, sign_r_next;
    logic [2*DATA_W-1:0]   result, result_next;
    logic                  ready, ready_next;
    logic                  stall_req;

    logic [2*DATA_W:0]     shifted;
    logic [2*DATA_W:0]     stepped;
    logic [DATA_W:0]       trial;
    logic [DATA_W-1:0]     quot, rem, quot_fix, rem_fix;
    logic [DATA_W-1:0]     abs1, abs2;

    // One restoring step on the working register {partial remainder, quotient}.
    always_comb begin
        shifted = work << 1;
        trial   = shifted[2*DATA_W:DATA_W] - {1'b0, divisor};
        if (!trial[DATA_W]) begin
            stepped = {1'b0, trial[DATA_W-1:0], shifted[DATA_W-1:1], 1'b1};
        end else begin
            stepped = shifted;
        end
        quot     = stepped[DATA_W-1:0];
        rem      = stepped[2*DATA_W-1:DATA_W];
        quot_fix = sign_q ? -quot : quot;
        rem_fix  = sign_r ? -rem : rem;
        abs1     = (bus.signed_div && bus.opdata1[DATA_W-1]) ? -bus.opdata1 : bus.opdata1;
        abs2     = (bus.signed_div && bus.opdata2[DATA_W-1]) ? -bus.opdata2 : bus.opdata2;
    end

    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        work_next    = work;
        divisor_next = divisor;
        sign_q_next  = sign_q;
        sign_r_next  = sign_r;
        result_next  = result;
        ready_next   = ready;
        stall_req    = 1'b0;

        if (bus.annul) begin
            state_next = IDLE;
            ready_next = 1'b0;
            cnt_next   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        stall_req = 1'b1;
                        if (bus.opdata2 == '0) begin
                            state_next = BYZERO;
                        end else begin
                            work_next    = {{(DATA_W+1){1'b0}}, abs1};
                            divisor_next = abs2;
                            sign_q_next  = bus.signed_div &
                                           (bus.opdata1[DATA_W-1] ^ bus.opdata2[DATA_W-1]);
                            sign_r_next  = bus.signed_div & bus.opdata1[DATA_W-1];
                            cnt_next     = '0;
                            state_next   = RUN;
                        end
                    end
                end
                BYZERO: begin
                    stall_req   = 1'b1;
                    result_next = '0;
                    ready_next  = 1'b1;
                    state_next  = DONE;
                end
                RUN: begin
                    stall_req = 1'b1;
                    work_next = stepped;
                    cnt_next  = cnt + CNT_W'(1);
                    if (cnt == CNT_W'(DATA_W - 1)) begin
                        result_next = {rem_fix, quot_fix};
                        ready_next  = 1'b1;
                        state_next  = DONE;
                    end
                end
                DONE: begin
                    // The requester holds start until it sees ready, so its release ends the op.
                    if (!bus.start) begin
                        ready_next = 1'b0;
                        state_next = IDLE;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            work    <= '0;
            divisor <= '0;
            sign_q  <= 1'b0;
            sign_r  <= 1'b0;
            result  <= '0;
            ready   <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            work    <= work_next;
            divisor <= divisor_next;
            sign_q  <= sign_q_next;
            sign_r  <= sign_r_next;
            result  <= result_next;
            ready   <= ready_next;
        end
    end

    assign bus.result    = result;
    assign bus.ready     = ready;
    assign bus.stall_req = stall_req;
endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: a vector table of divisions with hand-computed
// {HI, LO} results, plus annul and asynchronous-reset sequences.
module tb_div_seq;
    localparam int DATA_W = 32;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    div_seq_if #(.DATA_W(DATA_W)) bus ();

    div_seq #(.DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        sd;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [63:0] exp_res;
        int          exp_lat;
    } vec_t;

    vec_t vecs [12];
    int   checks   = 0;
    int   failures = 0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Runs one request with start held until ready; operands are scrambled after acceptance.
    task automatic applyStimulus(input logic sd, input logic [31:0] a, input logic [31:0] b,
                                 output int lat, output int stalls, output logic stall_at_ready,
                                 output logic [63:0] res, output logic ready_after,
                                 output logic [63:0] res_after);
        @(posedge clk); #1;
        bus.start      = 1'b1;
        bus.signed_div = sd;
        bus.opdata1    = a;
        bus.opdata2    = b;
        lat            = -1;
        stalls         = 0;
        stall_at_ready = 1'b0;
        res            = '0;
        for (int c = 0; c < 100; c++) begin
            #1;
            if (bus.ready) begin
                lat            = c;
                res            = bus.result;
                stall_at_ready = bus.stall_req;
                break;
            end
            if (bus.stall_req) stalls++;
            @(posedge clk); #1;
            if (c == 0) begin
                bus.opdata1    = ~a;
                bus.opdata2    = b + 32'd3;
                bus.signed_div = ~sd;
            end
        end
        bus.start = 1'b0;
        @(posedge clk); #2;
        ready_after = bus.ready;
        res_after   = bus.result;
    endtask

    int          lat, stalls;
    logic        stall_rdy, rdy_after;
    logic [63:0] res, res_after;
    logic        saw_ready;

    initial begin
        vecs[0]  = '{1'b0, 32'd100,       32'd7,        {32'd2,        32'd14},       33};
        vecs[1]  = '{1'b1, 32'hFFFFFFF9,  32'h2,        {32'hFFFFFFFF, 32'hFFFFFFFD}, 33};
        vecs[2]  = '{1'b1, 32'h7,         32'hFFFFFFFE, {32'h1,        32'hFFFFFFFD}, 33};
        vecs[3]  = '{1'b0, 32'h12345678,  32'h0,        64'h0,                        2};
        vecs[4]  = '{1'b1, 32'h80000000,  32'hFFFFFFFF, {32'h0,        32'h80000000}, 33};
        vecs[5]  = '{1'b0, 32'hFFFFFFFF,  32'h1,        {32'h0,        32'hFFFFFFFF}, 33};
        vecs[6]  = '{1'b0, 32'd50,        32'd5,        {32'd0,        32'd10},       33};
        vecs[7]  = '{1'b0, 32'hFFFFFFFF,  32'h10,       {32'hF,        32'h0FFFFFFF}, 33};
        vecs[8]  = '{1'b0, 32'd5,         32'd9,        {32'd5,        32'd0},        33};
        vecs[9]  = '{1'b1, 32'hFFFFFF9C,  32'hFFFFFFF9, {32'hFFFFFFFE, 32'd14},       33};
        vecs[10] = '{1'b0, 32'h80000000,  32'hFFFFFFFF, {32'h80000000, 32'h0},        33};
        vecs[11] = '{1'b1, 32'h0,         32'h0,        64'h0,                        2};

        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.annul      = 1'b0;
        bus.signed_div = 1'b0;
        bus.opdata1    = '0;
        bus.opdata2    = '0;
        #12;
        checkOutput("reset_ready",     {63'd0, bus.ready},     64'd0);
        checkOutput("reset_result",    bus.result,             64'd0);
        checkOutput("reset_stall_req", {63'd0, bus.stall_req}, 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].sd, vecs[i].op1, vecs[i].op2,
                          lat, stalls, stall_rdy, res, rdy_after, res_after);
            checkOutput($sformatf("v%0d_latency", i),      64'(lat),           64'(vecs[i].exp_lat));
            checkOutput($sformatf("v%0d_stall_cycles", i), 64'(stalls),        64'(vecs[i].exp_lat));
            checkOutput($sformatf("v%0d_stall_done", i),   {63'd0, stall_rdy}, 64'd0);
            checkOutput($sformatf("v%0d_result", i),       res,                vecs[i].exp_res);
            checkOutput($sformatf("v%0d_ready_drop", i),   {63'd0, rdy_after}, 64'd0);
            checkOutput($sformatf("v%0d_result_hold", i),  res_after,          vecs[i].exp_res);
        end

        // annul while idle must block acceptance of start
        @(posedge clk); #1;
        bus.start = 1'b1; bus.annul = 1'b1;
        bus.signed_div = 1'b0; bus.opdata1 = 32'd9; bus.opdata2 = 32'd3;
        #1;
        checkOutput("idle_annul_stall", {63'd0, bus.stall_req}, 64'd0);
        @(posedge clk); #1;
        bus.start = 1'b0; bus.annul = 1'b0;
        #1;
        checkOutput("idle_annul_not_run", {63'd0, bus.stall_req}, 64'd0);

        // annul in RUN cycle T+10
        @(posedge clk); #1;
        bus.start = 1'b1; bus.signed_div = 1'b0; bus.opdata1 = 32'd100; bus.opdata2 = 32'd7;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
        end
        #1;
        checkOutput("run_stall_before_annul", {63'd0, bus.stall_req}, 64'd1);
        bus.annul = 1'b1;
        #1;
        checkOutput("annul_stall_same_cycle", {63'd0, bus.stall_req}, 64'd0);
        @(posedge clk); #1;
        bus.annul = 1'b0; bus.start = 1'b0;
        #1;
        checkOutput("annul_back_to_idle", {63'd0, bus.stall_req}, 64'd0);
        saw_ready = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #2;
            if (bus.ready || bus.stall_req) saw_ready = 1'b1;
        end
        checkOutput("annul_no_ready", {63'd0, saw_ready}, 64'd0);
        applyStimulus(1'b0, 32'd50, 32'd5, lat, stalls, stall_rdy, res, rdy_after, res_after);
        checkOutput("post_annul_latency", 64'(lat), 64'd33);
        checkOutput("post_annul_result",  res,      {32'd0, 32'd10});

        // asynchronous reset pulse mid-RUN, between clock edges
        @(posedge clk); #1;
        bus.start = 1'b1; bus.signed_div = 1'b1; bus.opdata1 = 32'hFFFFFFF9; bus.opdata2 = 32'h2;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
        end
        #2;
        bus.start = 1'b0;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_ready",     {63'd0, bus.ready},     64'd0);
        checkOutput("async_rst_result",    bus.result,             64'd0);
        checkOutput("async_rst_stall_req", {63'd0, bus.stall_req}, 64'd0);
        #1;
        rst = 1'b0;
        applyStimulus(1'b0, 32'd100, 32'd7, lat, stalls, stall_rdy, res, rdy_after, res_after);
        checkOutput("post_rst_latency", 64'(lat), 64'd33);
        checkOutput("post_rst_result",  res,      {32'd2, 32'd14});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
